// File: rtl/usb_in_stream_arbiter.sv
// Shares the USB device IN byte stream between the DAP response source (0) and
// the CDC/UART RX source (1): round-robin at packet boundaries, split at MAX_PKT.
module usb_in_stream_arbiter #(
  parameter int MAX_PKT = 512
) (
  input  logic       hclk,
  input  logic       reset,
  input  logic [1:0] src_en,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tlast,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tlast,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       m_tdest,
  output logic       busy
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic [7:0]    m_tdata_q, m_tdata_d;
  logic          m_tlast_q, m_tlast_d;
  logic          m_tdest_q, m_tdest_d;

  logic [1:0] elig;
  logic       sel_tvalid;
  logic [7:0] sel_tdata;
  logic       sel_tlast;
  logic       out_free;
  logic       accept;
  logic       pkt_end;

  assign elig       = src_en & {s1_tvalid, s0_tvalid};
  assign sel_tvalid = sel_q ? s1_tvalid : s0_tvalid;
  assign sel_tdata  = sel_q ? s1_tdata  : s0_tdata;
  assign sel_tlast  = sel_q ? s1_tlast  : s0_tlast;

  // The output register can take a new byte when empty or draining this cycle.
  assign out_free = !m_tvalid_q || m_tready;
  assign accept   = (state_q == GRANT) && sel_tvalid && out_free;
  assign pkt_end  = sel_tlast || (cnt_q == CNT_LAST);

  assign s0_tready = (state_q == GRANT) && !sel_q && out_free;
  assign s1_tready = (state_q == GRANT) &&  sel_q && out_free;
  assign busy      = (state_q == GRANT);

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdest  = m_tdest_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tdest_d  = m_tdest_q;

    if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          sel_d   = (elig == 2'b11) ? rr_q : elig[1];
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = sel_tdata;
          m_tdest_d  = sel_q;
          m_tlast_d  = pkt_end;
          cnt_d      = cnt_q + CW'(1);
          // A forced split also hands priority to the other source.
          if (pkt_end) begin
            rr_d    = !sel_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 8'h00;
      m_tlast_q  <= 1'b0;
      m_tdest_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tdest_q  <= m_tdest_d;
    end
  end

endmodule
